// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and a constant-foldable clog2 for
// sizing pointers and occupancy counters across FIFO variants.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param; master is the
// client side driving requests, slave is the FIFO itself.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  localparam int AW = clog2(DEPTH);

  logic              wr;
  logic [DATA_W-1:0] datain;
  logic              rd;
  logic [DATA_W-1:0] dataout;
  logic              dout_vld;
  logic [AW:0]       level;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              full_err;
  logic              empty_err;

  modport master (
    output wr, datain, rd,
    input  dataout, dout_vld, level, full, empty,
           almost_full, almost_empty, full_err, empty_err
  );

  modport slave (
    input  wr, datain, rd,
    output dataout, dout_vld, level, full, empty,
           almost_full, almost_empty, full_err, empty_err
  );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write port plus a registered read port.
// The array itself is never reset; only the read register is.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      re,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value between accepted reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy, flags and error pulses
// around a fifo_ram storage block.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_fifo_param_if.slave   bus
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   DEPTH_LV = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_LV    = (AW+1)'(AF_LVL);
  localparam logic [AW:0]   AE_LV    = (AW+1)'(AE_LVL);

  generate
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (DATA_W < 1) ||
        (AF_LVL < 1) || (AF_LVL > DEPTH) || (AE_LVL < 0) || (AE_LVL > DEPTH - 1)) begin : g_param_chk
      $fatal(1, "sync_fifo_param: illegal DEPTH/AF_LVL/AE_LVL/DATA_W");
    end
  endgenerate

  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       level_r;
  logic              dout_vld_r;
  logic              full_err_r;
  logic              empty_err_r;
  logic              full_s;
  logic              empty_s;
  logic              rd_ok_s;
  logic              wr_ok_s;
  logic [DATA_W-1:0] dataout_s;

  // Acceptance: a read frees a slot in the same cycle, so a full FIFO still takes a write
  always_comb begin
    empty_s = (level_r == '0);
    full_s  = (level_r == DEPTH_LV);
    rd_ok_s = bus.rd && !empty_s;
    wr_ok_s = bus.wr && (!full_s || rd_ok_s);
  end

  // Pointers, occupancy, read strobe and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      dout_vld_r  <= 1'b0;
      full_err_r  <= 1'b0;
      empty_err_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
      dout_vld_r  <= rd_ok_s;
      full_err_r  <= bus.wr && !wr_ok_s;
      empty_err_r <= bus.rd && empty_s;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok_s),
    .waddr (wr_ptr_r),
    .wdata (bus.datain),
    .re    (rd_ok_s),
    .raddr (rd_ptr_r),
    .rdata (dataout_s)
  );

  assign bus.dataout      = dataout_s;
  assign bus.dout_vld     = dout_vld_r;
  assign bus.level        = level_r;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (level_r >= AF_LV);
  assign bus.almost_empty = (level_r <= AE_LV);
  assign bus.full_err     = full_err_r;
  assign bus.empty_err    = empty_err_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed scenarios on an 8x16 instance and random
// traffic on a 32x4 instance, both checked against queue-based models.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(8),  .DEPTH(16)) b8 ();
  sync_fifo_param_if #(.DATA_W(32), .DEPTH(4))  b32 ();

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8.slave));
  sync_fifo_param #(.DATA_W(32), .DEPTH(4), .AF_LVL(3), .AE_LVL(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b32.slave));

  // Reference model state: queue contents plus last-cycle expectations
  logic [7:0]  q8[$];
  logic [7:0]  e8_dout;
  logic        e8_vld, e8_ferr, e8_eerr;
  logic [31:0] q32[$];
  logic [31:0] e32_dout;
  logic        e32_vld, e32_ferr, e32_eerr;

  localparam logic [19:0] RST8  = {8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [41:0] RST32 = {32'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  function automatic logic [19:0] obs8();
    return {b8.dataout, b8.dout_vld, b8.level, b8.full, b8.empty,
            b8.almost_full, b8.almost_empty, b8.full_err, b8.empty_err};
  endfunction

  function automatic logic [19:0] exp8();
    int n = q8.size();
    return {e8_dout, e8_vld, 5'(n), n == 16, n == 0, n >= 14, n <= 2, e8_ferr, e8_eerr};
  endfunction

  function automatic logic [41:0] obs32();
    return {b32.dataout, b32.dout_vld, b32.level, b32.full, b32.empty,
            b32.almost_full, b32.almost_empty, b32.full_err, b32.empty_err};
  endfunction

  function automatic logic [41:0] exp32();
    int n = q32.size();
    return {e32_dout, e32_vld, 3'(n), n == 4, n == 0, n >= 3, n <= 1, e32_ferr, e32_eerr};
  endfunction

  task automatic model8_reset();
    q8.delete();
    e8_dout = 8'h00; e8_vld = 1'b0; e8_ferr = 1'b0; e8_eerr = 1'b0;
  endtask

  task automatic model32_reset();
    q32.delete();
    e32_dout = 32'h0; e32_vld = 1'b0; e32_ferr = 1'b0; e32_eerr = 1'b0;
  endtask

  // One clock of the 8-bit FIFO: drive, predict from pre-edge state, advance
  task automatic step8(input logic w, input logic r, input logic [7:0] d);
    logic rok, wok;
    b8.wr = w; b8.rd = r; b8.datain = d;
    rok = r && (q8.size() > 0);
    wok = w && ((q8.size() < 16) || rok);
    e8_ferr = w && !wok;
    e8_eerr = r && (q8.size() == 0);
    e8_vld  = rok;
    if (rok) e8_dout = q8.pop_front();
    if (wok) q8.push_back(d);
    @(posedge clk); #1;
    b8.wr = 1'b0; b8.rd = 1'b0;
  endtask

  task automatic step32(input logic w, input logic r, input logic [31:0] d);
    logic rok, wok;
    b32.wr = w; b32.rd = r; b32.datain = d;
    rok = r && (q32.size() > 0);
    wok = w && ((q32.size() < 4) || rok);
    e32_ferr = w && !wok;
    e32_eerr = r && (q32.size() == 0);
    e32_vld  = rok;
    if (rok) e32_dout = q32.pop_front();
    if (wok) q32.push_back(d);
    @(posedge clk); #1;
    b32.wr = 1'b0; b32.rd = 1'b0;
  endtask

  task automatic test_reset();
    b8.wr = 1'b0; b8.rd = 1'b0; b8.datain = 8'h00;
    b32.wr = 1'b0; b32.rd = 1'b0; b32.datain = 32'h0;
    rst_n = 1'b0;
    #12;
    tests_run++;
    if (obs8() !== RST8) begin
      tests_failed++;
      $display("FAIL reset8 got %h exp %h", obs8(), RST8);
    end
    tests_run++;
    if (obs32() !== RST32) begin
      tests_failed++;
      $display("FAIL reset32 got %h exp %h", obs32(), RST32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model8_reset();
    model32_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 17; i++) begin
      step8(1'b1, 1'b0, 8'(i));
      tests_run++;
      if (obs8() !== exp8()) begin
        tests_failed++;
        $display("FAIL fill_%0d got %h exp %h", i, obs8(), exp8());
      end
    end
    step8(1'b0, 1'b0, 8'h00);
    tests_run++;
    if (b8.full_err !== 1'b0 || b8.level !== 5'd16) begin
      tests_failed++;
      $display("FAIL fill_err_clear got ferr=%b lvl=%0d exp ferr=0 lvl=16", b8.full_err, b8.level);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 17; i++) begin
      step8(1'b0, 1'b1, 8'h00);
      tests_run++;
      if (obs8() !== exp8() || b8.dataout !== 8'(i < 16 ? i : 15)) begin
        tests_failed++;
        $display("FAIL drain_%0d got %h exp %h", i, obs8(), exp8());
      end
    end
  endtask

  task automatic test_wrap();
    int lens[4] = '{10, 10, 12, 12};
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < lens[p]; i++) begin
        step8(p[0] == 1'b0, p[0] == 1'b1, 8'($urandom));
        tests_run++;
        if (obs8() !== exp8()) begin
          tests_failed++;
          $display("FAIL wrap_p%0d_%0d got %h exp %h", p, i, obs8(), exp8());
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] w;
    for (int i = 0; i < 16; i++) step8(1'b1, 1'b0, 8'($urandom));
    step8(1'b1, 1'b1, 8'hA5);
    tests_run++;
    if (obs8() !== exp8()) begin
      tests_failed++;
      $display("FAIL simul_full got %h exp %h", obs8(), exp8());
    end
    for (int i = 0; i < 16; i++) begin
      step8(1'b0, 1'b1, 8'h00);
      tests_run++;
      if (obs8() !== exp8()) begin
        tests_failed++;
        $display("FAIL simul_drain_%0d got %h exp %h", i, obs8(), exp8());
      end
    end
    w = 8'($urandom);
    step8(1'b1, 1'b1, w);
    tests_run++;
    if (obs8() !== exp8() || b8.empty_err !== 1'b1 || b8.level !== 5'd1) begin
      tests_failed++;
      $display("FAIL simul_empty got %h exp %h", obs8(), exp8());
    end
    step8(1'b0, 1'b1, 8'h00);
    tests_run++;
    if (b8.dataout !== w || b8.dout_vld !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_empty_read got %h/%b exp %h/1", b8.dataout, b8.dout_vld, w);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    for (int i = 0; i < 9; i++) step8(1'b1, 1'b0, 8'($urandom_range(1, 255)));
    step8(1'b0, 1'b1, 8'h00);
    step8(1'b0, 1'b1, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs8() !== RST8) begin
      tests_failed++;
      $display("FAIL reset_mid got %h exp %h", obs8(), RST8);
    end
    rst_n = 1'b1;
    model8_reset();
    model32_reset();
    w = 8'($urandom);
    step8(1'b1, 1'b0, w);
    step8(1'b0, 1'b1, 8'h00);
    tests_run++;
    if (obs8() !== exp8() || b8.dataout !== w) begin
      tests_failed++;
      $display("FAIL reset_mid_rw got %h exp %h", obs8(), exp8());
    end
  endtask

  task automatic test_random32();
    int ph;
    logic w, r;
    for (int i = 0; i < 300; i++) begin
      ph = (i / 25) % 3;
      case (ph)
        0:       begin w = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0); end
        1:       begin w = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0); end
        default: begin w = 1'($urandom_range(0, 1));    r = 1'($urandom_range(0, 1));    end
      endcase
      step32(w, r, $urandom);
      tests_run++;
      if (obs32() !== exp32()) begin
        tests_failed++;
        $display("FAIL rand32_%0d got %h exp %h", i, obs32(), exp32());
      end
    end
  endtask

  task automatic test_random8();
    for (int i = 0; i < 200; i++) begin
      step8(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      tests_run++;
      if (obs8() !== exp8()) begin
        tests_failed++;
        $display("FAIL rand8_%0d got %h exp %h", i, obs8(), exp8());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_random8();
    test_random32();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO with configurable data width and depth. Supports simultaneous read and write in the same cycle, an occupancy count output, programmable almost-full/almost-empty flags and a read-data-valid strobe. It is the general-purpose single-clock buffer between producer and consumer logic on one clock domain, replacing fixed 8-bit/16-entry instances.

## Interface
- DATA_W, 8, data width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=4
- AF_LVL, DEPTH-2, almost_full asserted when level >= AF_LVL (1..DEPTH)
- AE_LVL, 2, almost_empty asserted when level <= AE_LVL (0..DEPTH-1)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr  in  1  write request, active high
- datain  in  DATA_W  write data, sampled with wr
- rd  in  1  read request, active high
- dataout  out  DATA_W  read data, registered
- dout_vld  out  1  one-cycle pulse: dataout updated this cycle
- level  out  AW+1  current occupancy, AW = log2(DEPTH)
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_LVL
- almost_empty  out  1  level <= AE_LVL
- full_err  out  1  registered pulse: write rejected because full
- empty_err  out  1  registered pulse: read rejected because empty

## Operation
- Write accepted (wr_ok) = wr && (!full || rd_ok); read accepted (rd_ok) = rd && !empty. Acceptance is evaluated against state at the clock edge.
- wr_ok: mem[wr_ptr] <= datain; wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0 (AW-bit pointer, natural wrap).
- rd_ok: dataout <= mem[rd_ptr]; rd_ptr <= rd_ptr+1 with same wrap; dout_vld <= 1. Otherwise dataout holds its previous value, dout_vld <= 0.
- level <= level + wr_ok - rd_ok; never exceeds DEPTH nor goes below 0.
- Simultaneous rd+wr:
  - not empty, not full: both accepted, level unchanged.
  - full: read accepted, so write also accepted; level stays DEPTH, no full_err.
  - empty: write accepted, read rejected; empty_err pulses, level -> 1. No write-through bypass.
- full_err <= wr && !wr_ok; empty_err <= rd && empty. Both deassert next cycle unless the condition repeats.
- Flags are decoded from the level register; no separate flag state.
- Storage array is not reset; contents are undefined until written.

## Timing
- Reset (async assert, sync-to-clk deassert at the boundary): level 0, pointers 0, dataout 0, dout_vld 0, empty 1, almost_empty 1, full 0, almost_full 0 (AF_LVL >= 1), full_err 0, empty_err 0.
- Reset mid-operation discards all entries immediately; first post-reset write lands at address 0.
- Read latency: rd asserted at edge N -> dataout/dout_vld valid after edge N, held until next accepted read.
- Write-to-read latency: data written at edge N is readable by rd at edge N+1 (empty deasserts after edge N).
- Flags and level update on the same edge as the accepted operation. No combinational path from wr/rd to any output.

## Structure
- Package fifo_pkg: a clog2 constant function and the default DATA_W/DEPTH values, shared with other FIFO variants.
- Sub-module fifo_ram: simple dual-port array, one synchronous write port and one registered read port, parametrised DATA_W/DEPTH. Pointers, level, flags and error logic stay in sync_fifo_param.
- Elaboration check: DEPTH not a power of two, or AF_LVL/AE_LVL out of range, triggers a fatal error.

## Test plan
- Reset then fill: 16 writes of 0x00..0x0F (DATA_W 8, DEPTH 16) -> level 16, full 1, almost_full from level 14; 17th write -> full_err one cycle, contents unchanged.
- Drain: 16 reads -> dataout 0x00..0x0F in order, dout_vld each cycle, empty after last; 17th read -> empty_err, dataout holds 0x0F.
- Wrap: write 10, read 10, write 12, read 12 -> data in order across pointer wrap, level back to 0.
- Simultaneous at full: rd+wr with level 16 -> oldest word out, new word stored, level stays 16, no errors; at empty: rd+wr -> empty_err 1, level 1, next read returns written word.
- Reset asserted with level 7 mid-stream -> all outputs reach reset values without clock; next write/read returns that new word.
- Second configuration DATA_W 32, DEPTH 4, AF_LVL 3, AE_LVL 1 -> flag thresholds and wrap verified with random rd/wr against a reference queue model.
